// File: rtl/cic_interp.sv
// CIC interpolator: STAGES comb sections at the input rate, zero stuffing, and
// STAGES integrator sections at the out_strobe rate, with rounded/saturated output.
module cic_interp #(
    parameter int STAGES    = 3,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int L2MD      = 6,
    parameter int ACC_WIDTH = IN_WIDTH + STAGES * L2MD
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [7:0]                  interpolation,
    input  logic                        out_strobe,
    output logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    // Strobe protocol: out_strobe is a one-clock tick from the DAC side. in_strobe
    // is a one-clock request raised in the same cycle; the source must hold the next
    // sample on in_data during it. There is no back-pressure in either direction.

    typedef enum logic [1:0] {RATE_5, RATE_10, RATE_20, RATE_40} rate_t;

    function automatic int gain_bits(input int rate);
        longint p;
        int     g;
        p = 1;
        g = 0;
        for (int i = 0; i < STAGES - 1; i++) p = p * longint'(rate);
        for (int i = 0; i < 63; i++) if ((longint'(1) << g) < p) g++;
        return g;
    endfunction

    localparam int G5  = gain_bits(5);
    localparam int G10 = gain_bits(10);
    localparam int G20 = gain_bits(20);
    localparam int G40 = gain_bits(40);

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Round at bit msb-OUT_WIDTH, clamp when the kept field plus round-up overflows
    // or when acc has significant bits above msb.
    function automatic logic signed [OUT_WIDTH-1:0] quantize(
        input logic signed [ACC_WIDTH-1:0] acc,
        input int                          g
    );
        logic signed [ACC_WIDTH-1:0] pre;
        logic signed [ACC_WIDTH-1:0] kept;
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [OUT_WIDTH-1:0] field;
        logic                        rbit;
        pre   = acc >>> (IN_WIDTH + g - OUT_WIDTH - 1);
        rbit  = pre[0];
        kept  = pre >>> 1;
        hi    = kept >>> (OUT_WIDTH - 1);
        field = kept[OUT_WIDTH-1:0];
        if (!(hi == '0 || hi == '1))
            return acc[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
        else if (field == OUT_MAX && rbit)
            return OUT_MAX;
        else
            return field + {{(OUT_WIDTH-1){1'b0}}, rbit};
    endfunction

    rate_t                        rate_req;
    rate_t                        rate_q;
    logic                         started;
    logic                         flush;
    logic                         strobe_d;
    logic [L2MD-1:0]              phase;
    logic [L2MD-1:0]              phase_last;
    logic signed [ACC_WIDTH-1:0]  comb_dly [STAGES];
    logic signed [ACC_WIDTH-1:0]  comb_in  [STAGES];
    logic signed [ACC_WIDTH-1:0]  comb_new;
    logic signed [ACC_WIDTH-1:0]  comb_out;
    logic signed [ACC_WIDTH-1:0]  integ    [STAGES];
    logic signed [OUT_WIDTH-1:0]  out_next;

    always_comb begin
        case (interpolation)
            8'd5:    rate_req = RATE_5;
            8'd10:   rate_req = RATE_10;
            8'd20:   rate_req = RATE_20;
            default: rate_req = RATE_40;
        endcase
    end

    always_comb begin
        case (rate_q)
            RATE_5:  phase_last = L2MD'(4);
            RATE_10: phase_last = L2MD'(9);
            RATE_20: phase_last = L2MD'(19);
            default: phase_last = L2MD'(39);
        endcase
    end

    always_comb begin
        case (rate_q)
            RATE_5:  out_next = quantize(integ[STAGES-1], G5);
            RATE_10: out_next = quantize(integ[STAGES-1], G10);
            RATE_20: out_next = quantize(integ[STAGES-1], G20);
            default: out_next = quantize(integ[STAGES-1], G40);
        endcase
    end

    always_comb begin
        logic signed [ACC_WIDTH-1:0] x;
        x = ACC_WIDTH'(in_data);
        for (int k = 0; k < STAGES; k++) begin
            comb_in[k] = x;
            x = x - comb_dly[k];
        end
        comb_new = x;
    end

    assign in_strobe = reset_n && out_strobe && !flush && (phase == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rate_q   <= RATE_40;
            started  <= 1'b0;
            flush    <= 1'b0;
            strobe_d <= 1'b0;
            phase    <= '0;
            comb_out <= '0;
            out_data <= '0;
            for (int k = 0; k < STAGES; k++) begin
                comb_dly[k] <= '0;
                integ[k]    <= '0;
            end
        end else begin
            // Right after reset everything is already clear, so the first rate load
            // must not raise a flush that would swallow the first in_strobe.
            started  <= 1'b1;
            rate_q   <= rate_req;
            flush    <= started && (rate_req != rate_q);
            strobe_d <= out_strobe;
            if (flush) begin
                phase    <= '0;
                comb_out <= '0;
                out_data <= '0;
                for (int k = 0; k < STAGES; k++) begin
                    comb_dly[k] <= '0;
                    integ[k]    <= '0;
                end
            end else begin
                if (in_strobe) begin
                    for (int k = 0; k < STAGES; k++) comb_dly[k] <= comb_in[k];
                    comb_out <= comb_new;
                end
                if (out_strobe) begin
                    phase    <= (phase == phase_last) ? '0 : phase + 1'b1;
                    integ[0] <= integ[0] + ((phase == '0) ? comb_out : '0);
                    for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
                end
                if (strobe_d) out_data <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: arithmetic model (Nth difference, zero-stuffed running sums,
// round/clamp by division) checked every cycle, plus hand-computed settling values.
module tb_cic_interp;

    localparam int STAGES    = 3;
    localparam int IN_WIDTH  = 18;
    localparam int OUT_WIDTH = 18;
    localparam int L2MD      = 6;
    localparam int ACC_WIDTH = IN_WIDTH + STAGES * L2MD;

    logic                        clock = 1'b0;
    logic                        reset_n = 1'b0;
    logic [7:0]                  interpolation = 8'd10;
    logic                        out_strobe = 1'b0;
    logic                        in_strobe;
    logic signed [IN_WIDTH-1:0]  in_data = '0;
    logic signed [OUT_WIDTH-1:0] out_data;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    cic_interp #(
        .STAGES(STAGES), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .L2MD(L2MD), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .interpolation(interpolation),
        .out_strobe(out_strobe), .in_strobe(in_strobe),
        .in_data(in_data), .out_data(out_data)
    );

    // ---------------- clock/reset ----------------
    always #5 clock = ~clock;

    // ---------------- model ----------------
    longint m_hist [STAGES+1];
    longint m_int  [STAGES];
    longint m_comb = 0;
    longint m_out  = 0;
    int     m_phase = 0;
    int     m_rate  = 40;
    bit     m_flush = 1'b0;
    bit     m_pend  = 1'b0;
    bit     m_started = 1'b0;
    bit     m_ins;
    bit     m_new_flush;
    bit     exp_ins;
    longint m_sum;

    function automatic int eff_rate(input logic [7:0] v);
        if (v == 8'd5 || v == 8'd10 || v == 8'd20 || v == 8'd40) return int'(v);
        return 40;
    endfunction

    function automatic longint wrap_acc(input longint x);
        return (x <<< (64 - ACC_WIDTH)) >>> (64 - ACC_WIDTH);
    endfunction

    function automatic int gain_of(input int r);
        longint p;
        int     g;
        p = 1;
        g = 0;
        for (int i = 0; i < STAGES - 1; i++) p = p * r;
        while ((longint'(1) <<< g) < p) g++;
        return g;
    endfunction

    function automatic longint binom_signed(input int j);
        longint c;
        c = 1;
        for (int i = 0; i < j; i++) c = c * (STAGES - i) / (i + 1);
        return (j % 2 == 1) ? -c : c;
    endfunction

    function automatic longint quant(input longint acc, input int r);
        int     s;
        longint q;
        longint hi_lim;
        longint lo_lim;
        s = IN_WIDTH + gain_of(r) - OUT_WIDTH;
        q = (acc + (longint'(1) <<< (s - 1))) >>> s;
        hi_lim = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
        lo_lim = -(longint'(1) <<< (OUT_WIDTH - 1));
        if (q > hi_lim) q = hi_lim;
        if (q < lo_lim) q = lo_lim;
        return q;
    endfunction

    task automatic model_clear();
        for (int k = 0; k <= STAGES; k++) m_hist[k] = 0;
        for (int k = 0; k < STAGES; k++) m_int[k] = 0;
        m_comb  = 0;
        m_phase = 0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
            m_out = 0; m_rate = 40; m_flush = 1'b0; m_pend = 1'b0; m_started = 1'b0;
        end else begin
            m_ins       = out_strobe && (m_phase == 0) && !m_flush;
            m_new_flush = m_started && (eff_rate(interpolation) != m_rate);
            if (m_flush) begin
                model_clear();
                m_out = 0;
            end else begin
                if (m_pend) m_out = quant(m_int[STAGES-1], m_rate);
                if (out_strobe) begin
                    for (int k = STAGES - 1; k >= 1; k--) m_int[k] = wrap_acc(m_int[k] + m_int[k-1]);
                    m_int[0] = wrap_acc(m_int[0] + ((m_phase == 0) ? m_comb : 0));
                    m_phase  = (m_phase + 1) % m_rate;
                end
                if (m_ins) begin
                    for (int k = STAGES; k >= 1; k--) m_hist[k] = m_hist[k-1];
                    m_hist[0] = longint'(in_data);
                    m_sum = 0;
                    for (int j = 0; j <= STAGES; j++) m_sum += binom_signed(j) * m_hist[j];
                    m_comb = wrap_acc(m_sum);
                end
            end
            m_pend    = out_strobe;
            m_flush   = m_new_flush;
            m_rate    = eff_rate(interpolation);
            m_started = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string what, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", what, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        #1;
        if (cmp_en) begin
            exp_ins = reset_n && out_strobe && (m_phase == 0) && !m_flush;
            check("in_strobe", longint'(in_strobe), longint'(exp_ins));
            check("out_data", longint'(out_data), m_out);
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            out_strobe = 1'b0;
        end
    endtask

    task automatic run_ticks(input int n, input int gap, input int period,
                             input int exp_pulses, input string name);
        int pulses;
        int misplaced;
        pulses = 0;
        misplaced = 0;
        for (int t = 0; t < n; t++) begin
            @(negedge clock);
            out_strobe = 1'b1;
            #2;
            if (in_strobe) begin
                pulses++;
                if (t % period != 0) misplaced++;
            end
            for (int g = 1; g < gap; g++) begin
                @(negedge clock);
                out_strobe = 1'b0;
            end
        end
        idle(1);
        check({name, "_pulse_count"}, pulses, exp_pulses);
        check({name, "_pulse_misplaced"}, misplaced, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        interpolation = 8'd10;
        in_data = 18'sd1000;
        idle(3);
        cmp_en = 1'b1;
        #1;
        check("reset_out_data", longint'(out_data), 0);
        check("reset_in_strobe", longint'(in_strobe), 0);

        @(negedge clock);
        reset_n = 1'b1;
        run_ticks(200, 4, 10, 20, "r10_pos");
        check("r10_settle_pos", longint'(out_data), 781);

        in_data = -18'sd1000;
        run_ticks(200, 4, 10, 20, "r10_neg");
        check("r10_settle_neg", longint'(out_data), -781);

        // reset mid-stream with a strobe present
        @(negedge clock);
        out_strobe = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midreset_out_data", longint'(out_data), 0);
        check("midreset_in_strobe", longint'(in_strobe), 0);
        idle(3);
        reset_n = 1'b1;
        @(negedge clock);
        out_strobe = 1'b1;
        #2;
        check("post_reset_first_in_strobe", longint'(in_strobe), 1);
        idle(4);

        interpolation = 8'd5;
        in_data = 18'sd32000;
        idle(3);
        run_ticks(150, 4, 5, 30, "r5");
        check("r5_settle", longint'(out_data), 25000);

        interpolation = 8'd10;
        in_data = 18'sd1000;
        idle(3);
        run_ticks(200, 4, 10, 20, "r10_again");
        check("r10_settle_again", longint'(out_data), 781);

        // 10 -> 20 with a strobe landing in the flush cycle
        @(negedge clock);
        interpolation = 8'd20;
        @(negedge clock);
        out_strobe = 1'b1;
        #2;
        check("flush_cycle_in_strobe", longint'(in_strobe), 0);
        @(negedge clock);
        out_strobe = 1'b0;
        #2;
        check("flush_out_data", longint'(out_data), 0);
        run_ticks(300, 4, 20, 15, "r20");
        check("r20_settle", longint'(out_data), 781);

        // unsupported rate behaves as 40; full-scale steps
        interpolation = 8'd7;
        in_data = 18'sd131071;
        idle(3);
        run_ticks(200, 2, 40, 5, "r7_pos");
        check("r7_settle_pos", longint'(out_data), 102399);
        in_data = -18'sd131072;
        run_ticks(200, 2, 40, 5, "r7_neg");
        check("r7_settle_neg", longint'(out_data), -102400);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning the number of comb sections and the number of integrator sections.
REQ-002 SHALL have parameter IN_WIDTH, default 18, meaning the signed input sample width.
REQ-003 SHALL have parameter OUT_WIDTH, default 18, meaning the signed output sample width.
REQ-004 SHALL have parameter L2MD, default 6, meaning ceil(log2) of the maximum interpolation rate.
REQ-005 SHALL have parameter ACC_WIDTH, default IN_WIDTH+STAGES*L2MD, meaning the internal comb/integrator width.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port interpolation, input, 8 bits: rate R; supported values 5, 10, 20, 40.
REQ-009 SHALL have port out_strobe, input, 1 bit: high-rate sample tick, one clock wide, from the DAC side.
REQ-010 SHALL have port in_strobe, output, 1 bit: one-clock request; the upstream source presents the next sample during it.
REQ-011 SHALL have port in_data, input, IN_WIDTH bits, signed: low-rate sample, sampled in the in_strobe cycle.
REQ-012 SHALL have port out_data, output, OUT_WIDTH bits, signed: registered high-rate output.

Function
REQ-013 SHALL keep a phase counter (L2MD bits) that advances on each out_strobe and wraps from R-1 to 0.
REQ-014 SHALL assert in_strobe combinationally in any cycle with out_strobe=1 and phase=0; otherwise in_strobe=0.
REQ-015 SHALL map an unsupported interpolation value to behave exactly as R=40, including the counter wrap.
REQ-016 SHALL, in the in_strobe cycle, register in_data through STAGES comb sections (differentiator y=x-x_prev per section, ACC_WIDTH, sign-extended input) in one update.
REQ-017 SHALL perform zero-stuffing: on each out_strobe, integrator 1 adds the comb output if phase=0, else adds 0.
REQ-018 SHALL update integrator k+1 from the pre-update values of integrators k and k+1 on each out_strobe, as a pipelined cascade.
REQ-019 SHALL update all comb and integrator arithmetic only on strobes, with two's-complement wrap at ACC_WIDTH (no saturation internally).
REQ-020 SHALL use gain growth G = ceil(log2(R^(STAGES-1))); for STAGES=3, G = 5, 7, 9, 11 for R = 5, 10, 20, 40.
REQ-021 SHALL set msb = IN_WIDTH+G-1 and compute rounded = acc[msb -: OUT_WIDTH] + acc[msb-OUT_WIDTH], where acc is the last integrator.
REQ-022 SHALL saturate rounded to the signed OUT_WIDTH maximum when the round-up carry overflows, or when the bits of acc above msb differ from acc[msb] (clamp to max or min by sign).
REQ-023 SHALL register out_data in the clock after each out_strobe from the post-update last integrator; latency is 1 clock from out_strobe.
REQ-024 SHALL hold out_data between out_strobes.
REQ-025 SHALL detect a change of interpolation (registered compare) and, in the following clock, clear the phase, all comb, comb-delay and integrator registers, and out_data (synchronous flush).
REQ-026 SHALL, when a flush coincides with out_strobe, perform the flush, suppress in_strobe for that cycle, and leave out_data=0.
REQ-027 SHALL give zero DC steady state: with constant input X, out_data converges to round(X*R^(STAGES-1)/2^G).

Reset
REQ-028 SHALL, while reset_n=0, force phase=0, all comb/delay/integrator registers to 0, out_data=0 and the registered rate to R=40 encoding, asynchronously.
REQ-029 SHALL not assert in_strobe while reset_n=0, and SHALL resume normal operation on the first out_strobe after release; the first strobe has phase=0 and asserts in_strobe.

Verification
REQ-030 SHALL cover: reset asserted mid-stream at R=10 -> out_data=0 and in_strobe=0 immediately; after release, the first out_strobe asserts in_strobe.
REQ-031 SHALL cover: R=10, out_strobe every 4 clocks for 200 ticks -> in_strobe on ticks 0, 10, 20, ... exactly; 20 pulses total.
REQ-032 SHALL cover: R=10, in_data=+1000 constant -> out_data settles at 781; in_data=-1000 -> out_data settles at -781.
REQ-033 SHALL cover: R=5, in_data=32000 constant -> out_data settles at 25000.
REQ-034 SHALL cover: R switched 10->20 mid-stream -> flush one clock later, out_data=0, phase restarts at 0, and the new settling value for in_data=1000 is round(1000*400/512)=781.
REQ-035 SHALL cover: interpolation=7 -> in_strobe every 40 out_strobes; a full-scale step +131071 <-> -131072 produces no wrap, only saturation at ±(2^17-1)/-2^17.
